// File: rtl/pattern_pkg.sv
// rtl/pattern_pkg.sv - shared state encodings, symbol and pattern constants for the bit-stream blocks
package pattern_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // Symbol encoding on the serial line
  localparam logic B = 1'b0;
  localparam logic C = 1'b1;

  // Pattern the downstream detector looks for, earliest symbol in the MSB
  localparam logic [4:0] PAT_BCCBC = 5'b01101;

  // Gap counter width, enough for GAP up to 15
  localparam int GAP_W = 4;

endpackage

// File: rtl/bit_stream_tx_if.sv
// rtl/bit_stream_tx_if.sv - load handshake plus serial data/valid bundle of the bit-stream transmitter
interface bit_stream_tx_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] data_i;
  logic             load_i;
  logic             ready_o;
  logic             d_o;
  logic             valid_o;

  // Word source / bit consumer side
  modport master (
    output data_i, load_i,
    input  ready_o, d_o, valid_o
  );

  // Transmitter side
  modport slave (
    input  data_i, load_i,
    output ready_o, d_o, valid_o
  );

endinterface

// File: rtl/bit_stream_tx.sv
// rtl/bit_stream_tx.sv - serial transmitter shifting loaded words out one bit per clock with optional idle gap
module bit_stream_tx
  import pattern_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int GAP       = 0,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  bit_stream_tx_if.slave   bus,
  output logic             busy_o,
  output logic [CNT_W-1:0] words_sent_o
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q;
  logic [BW-1:0]    bit_cnt_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic             d_q, d_d;
  logic             valid_q, busy_q;
  logic [CNT_W-1:0] words_q;

  logic ready;
  logic accept;
  logic last_bit;
  logic gap_done;
  logic first_bit;
  logic shift_head;
  logic [WIDTH-1:0] load_rest;
  logic [WIDTH-1:0] shift_rest;

  assign last_bit = (state_q == S_SHIFT) && (bit_cnt_q == BW'(WIDTH - 1));
  assign gap_done = (gap_cnt_q == GAP_W'(GAP - 1));

  // Ready depends only on state and bit position so the source can never loop through it
  assign ready  = (state_q == S_IDLE) || (last_bit && (GAP == 0));
  assign accept = bus.load_i && ready;

  // The first bit goes straight to the output register; the shift register keeps the rest
  assign first_bit  = (MSB_FIRST != 0) ? bus.data_i[WIDTH-1] : bus.data_i[0];
  assign shift_head = (MSB_FIRST != 0) ? shift_q[WIDTH-1]    : shift_q[0];
  assign load_rest  = (MSB_FIRST != 0) ? {bus.data_i[WIDTH-2:0], 1'b0}
                                       : {1'b0, bus.data_i[WIDTH-1:1]};
  assign shift_rest = (MSB_FIRST != 0) ? {shift_q[WIDTH-2:0], 1'b0}
                                       : {1'b0, shift_q[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and next serial bit; an unknown encoding falls back to IDLE
  always_comb begin
    state_d = state_q;
    d_d     = B;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (last_bit) begin
          if (GAP == 0) state_d = accept ? S_SHIFT : S_IDLE;
          else          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (accept)                                d_d = first_bit;
    else if ((state_q == S_SHIFT) && !last_bit) d_d = shift_head;
  end

  // Registered line outputs follow the next state so d_o is B whenever valid_o is low
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q     <= B;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      d_q     <= d_d;
      valid_q <= (state_d == S_SHIFT);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  // Shift register: capture on accept, advance one bit per SHIFT cycle
  always_ff @(posedge clk) begin
    if (rst)                     shift_q <= '0;
    else if (accept)             shift_q <= load_rest;
    else if (state_q == S_SHIFT) shift_q <= shift_rest;
  end

  // Bit counter tracks the bit currently on the line, back to 0 after the last one
  always_ff @(posedge clk) begin
    if (rst)                                   bit_cnt_q <= '0;
    else if ((state_q == S_SHIFT) && !last_bit) bit_cnt_q <= bit_cnt_q + 1'b1;
    else                                       bit_cnt_q <= '0;
  end

  // Gap counter times the idle cycles after each word
  always_ff @(posedge clk) begin
    if (rst)                                 gap_cnt_q <= '0;
    else if ((state_q == S_GAP) && !gap_done) gap_cnt_q <= gap_cnt_q + 1'b1;
    else                                     gap_cnt_q <= '0;
  end

  // Words-sent counter, wraps naturally at its width
  always_ff @(posedge clk) begin
    if (rst)           words_q <= '0;
    else if (last_bit) words_q <= words_q + 1'b1;
  end

  assign bus.ready_o  = ready;
  assign bus.d_o      = d_q;
  assign bus.valid_o  = valid_q;
  assign busy_o       = busy_q;
  assign words_sent_o = words_q;

endmodule

// File: tb/tb_bit_stream_tx.sv
// tb/tb_bit_stream_tx.sv - directed self-checking bench for bit_stream_tx
module tb_bit_stream_tx;
  import pattern_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bit_stream_tx_if #(.WIDTH(8)) if0 ();
  bit_stream_tx_if #(.WIDTH(8)) if1 ();
  bit_stream_tx_if #(.WIDTH(8)) if2 ();
  bit_stream_tx_if #(.WIDTH(8)) if3 ();

  logic        busy0, busy1, busy2, busy3;
  logic [15:0] words0, words1, words2;
  logic [1:0]  words3;

  bit_stream_tx #(.WIDTH(8), .GAP(0), .MSB_FIRST(1), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .bus(if0), .busy_o(busy0), .words_sent_o(words0));
  bit_stream_tx #(.WIDTH(8), .GAP(3), .MSB_FIRST(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .bus(if1), .busy_o(busy1), .words_sent_o(words1));
  bit_stream_tx #(.WIDTH(8), .GAP(0), .MSB_FIRST(0), .CNT_W(16)) u2 (
    .clk(clk), .rst(rst), .bus(if2), .busy_o(busy2), .words_sent_o(words2));
  bit_stream_tx #(.WIDTH(8), .GAP(0), .MSB_FIRST(1), .CNT_W(2)) u3 (
    .clk(clk), .rst(rst), .bus(if3), .busy_o(busy3), .words_sent_o(words3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  got;
  logic [7:0]  exp8;
  logic [15:0] exp16;
  logic [7:0]  wv [5];
  int          hits;

  initial begin
    if0.load_i = 1'b0; if0.data_i = '0;
    if1.load_i = 1'b0; if1.data_i = '0;
    if2.load_i = 1'b0; if2.data_i = '0;
    if3.load_i = 1'b0; if3.data_i = '0;

    // Reset for two edges
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", 32'(if0.valid_o), 32'd0);
    chk("rst_d", 32'(if0.d_o), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_words", 32'(words0), 32'd0);
    chk("rst_ready", 32'(if0.ready_o), 32'd1);

    // Single word, MSB first
    exp8 = 8'b0110_1101;
    if0.data_i = exp8;
    if0.load_i = 1'b1;
    tick();
    if0.load_i = 1'b0;
    if0.data_i = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk("single_valid", 32'(if0.valid_o), 32'd1);
      chk("single_d", 32'(if0.d_o), 32'(exp8[7-i]));
      got[7-i] = if0.d_o;
      tick();
    end
    chk("single_valid_end", 32'(if0.valid_o), 32'd0);
    chk("single_d_end", 32'(if0.d_o), 32'd0);
    chk("single_words", 32'(words0), 32'd1);
    chk("single_busy_end", 32'(busy0), 32'd0);
    hits = 0;
    for (int j = 0; j < 4; j++) if (got[7-j -: 5] == PAT_BCCBC) hits++;
    chk("single_pattern_hits", 32'(hits), 32'd2);

    // Back-to-back, load held high
    exp16 = 16'b1010_0101_0011_1100;
    chk("b2b_ready_idle", 32'(if0.ready_o), 32'd1);
    if0.data_i = 8'hA5;
    if0.load_i = 1'b1;
    tick();
    if0.data_i = 8'h3C;
    for (int i = 0; i < 16; i++) begin
      chk("b2b_valid", 32'(if0.valid_o), 32'd1);
      chk("b2b_d", 32'(if0.d_o), 32'(exp16[15-i]));
      chk("b2b_ready", 32'(if0.ready_o), 32'((i == 7) || (i == 15)));
      if (i == 8) if0.data_i = 8'hFF;
      if (i == 15) if0.load_i = 1'b0;
      tick();
    end
    chk("b2b_valid_end", 32'(if0.valid_o), 32'd0);
    chk("b2b_words", 32'(words0), 32'd3);

    // Gap insertion, GAP=3, load held high
    exp8 = 8'hC3;
    if1.data_i = exp8;
    if1.load_i = 1'b1;
    tick();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 8; i++) begin
        chk("gap_burst_valid", 32'(if1.valid_o), 32'd1);
        chk("gap_burst_d", 32'(if1.d_o), 32'(exp8[7-i]));
        chk("gap_burst_ready", 32'(if1.ready_o), 32'd0);
        tick();
      end
      for (int g = 0; g < 3; g++) begin
        chk("gap_valid", 32'(if1.valid_o), 32'd0);
        chk("gap_d", 32'(if1.d_o), 32'd0);
        chk("gap_busy", 32'(busy1), 32'd1);
        chk("gap_ready", 32'(if1.ready_o), 32'd0);
        tick();
      end
      chk("gap_idle_valid", 32'(if1.valid_o), 32'd0);
      chk("gap_idle_busy", 32'(busy1), 32'd0);
      chk("gap_idle_ready", 32'(if1.ready_o), 32'd1);
      if (r == 1) if1.load_i = 1'b0;
      tick();
    end
    chk("gap_words", 32'(words1), 32'd2);
    chk("gap_valid_end", 32'(if1.valid_o), 32'd0);

    // LSB first
    if2.data_i = 8'b0000_0001;
    if2.load_i = 1'b1;
    tick();
    if2.load_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("lsb_valid", 32'(if2.valid_o), 32'd1);
      chk("lsb_d", 32'(if2.d_o), 32'(i == 0));
      tick();
    end
    chk("lsb_words", 32'(words2), 32'd1);

    // Mid-word reset on the 4th bit
    if0.data_i = 8'hFF;
    if0.load_i = 1'b1;
    tick();
    if0.load_i = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("midrst_bit4_valid", 32'(if0.valid_o), 32'd1);
    chk("midrst_bit4_d", 32'(if0.d_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", 32'(if0.valid_o), 32'd0);
    chk("midrst_d", 32'(if0.d_o), 32'd0);
    chk("midrst_words", 32'(words0), 32'd0);
    chk("midrst_ready", 32'(if0.ready_o), 32'd1);
    chk("midrst_busy", 32'(busy0), 32'd0);
    exp8 = 8'h96;
    if0.data_i = exp8;
    if0.load_i = 1'b1;
    tick();
    if0.load_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("fresh_valid", 32'(if0.valid_o), 32'd1);
      chk("fresh_d", 32'(if0.d_o), 32'(exp8[7-i]));
      tick();
    end
    chk("fresh_words", 32'(words0), 32'd1);

    // Ignored load during SHIFT and counter wrap with CNT_W=2
    wv[0] = 8'hB4; wv[1] = 8'h0F; wv[2] = 8'h81; wv[3] = 8'h5A; wv[4] = 8'hE7;
    for (int w = 0; w < 5; w++) begin
      exp8 = wv[w];
      if3.data_i = exp8;
      if3.load_i = 1'b1;
      tick();
      if3.load_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
        chk("wrap_valid", 32'(if3.valid_o), 32'd1);
        chk("wrap_d", 32'(if3.d_o), 32'(exp8[7-i]));
        if (w == 0 && i == 2) begin
          chk("ign_ready", 32'(if3.ready_o), 32'd0);
          if3.load_i = 1'b1;
          if3.data_i = 8'h00;
        end
        if (w == 0 && i == 3) if3.load_i = 1'b0;
        tick();
      end
      chk("wrap_idle_valid", 32'(if3.valid_o), 32'd0);
      chk("wrap_words_step", 32'(words3), 32'((w + 1) % 4));
    end
    chk("wrap_words_final", 32'(words3), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bit_stream_tx.md
Name: bit_stream_tx

Overview:
Serial bit-stream transmitter that drives the single-bit data/valid interface consumed by the pattern detectors.
- Accepts parallel words through a valid/ready load handshake.
- Shifts each word out one bit per clock on d_o, with valid_o qualifying each bit.
- Inserts a programmable number of idle (valid_o=0) cycles between words.
- Used as the stimulus and traffic source in front of the detector block, both on-chip and in testbenches.

Parameters:
WIDTH, 8, bits per loaded word (legal values 2..32).
GAP, 0, idle cycles with valid_o=0 inserted after each word (legal values 0..15).
MSB_FIRST, 1, 1 = bit WIDTH-1 is transmitted first; 0 = bit 0 is transmitted first.
CNT_W, 16, width of the words-sent counter.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  synchronous reset, active-high.
data_i  input  WIDTH  word to transmit.
load_i  input  1  load request; the word is accepted on an edge where load_i && ready_o.
ready_o  output  1  transmitter can accept a word this cycle.
d_o  output  1  serial data bit (encoding: B=0, C=1).
valid_o  output  1  d_o carries a valid bit this cycle.
busy_o  output  1  high while in SHIFT or GAP.
words_sent_o  output  CNT_W  count of fully transmitted words.

Behaviour:
- Reset is synchronous: rst is high at a rising edge.
  - Reset values: state=IDLE, d_o=0, valid_o=0, busy_o=0, words_sent_o=0, shift register=0, bit and gap counters=0.
  - ready_o=1 from the first cycle after reset is released.
  - rst has priority over every other event; it aborts a word mid-shift with no partial count.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - valid_o=0, d_o=0, ready_o=1.
  - On an accept edge, data_i is captured into the shift register and the state goes to SHIFT.
- SHIFT:
  - d_o, valid_o and busy_o are registered outputs.
  - A word accepted at edge k is presented as bits on cycles k+1 .. k+WIDTH; valid_o=1 throughout, no bubbles.
  - Latency from accept to first valid bit is 1 cycle.
  - Bit order follows MSB_FIRST.
  - The bit counter runs 0..WIDTH-1.
- Last bit cycle (bit counter = WIDTH-1):
  - words_sent_o increments at the edge ending this cycle and wraps modulo 2^CNT_W.
  - If GAP=0: ready_o=1 during this cycle.
    - Accept at this edge: back-to-back transmission; the next word's first bit appears on the next cycle, and valid_o stays high continuously.
    - No accept: go to IDLE.
  - If GAP>0: ready_o=0 and the state goes to GAP.
- GAP:
  - Lasts exactly GAP cycles with valid_o=0, d_o=0, ready_o=0, busy_o=1.
  - Then goes to IDLE, where ready_o=1 on the following cycle.
- ready_o is combinational from state and bit counter only, never from load_i.
- load_i while ready_o=0 is ignored; the word is not queued.
- d_o must be 0 whenever valid_o=0 (no stale data).
- busy_o=1 in SHIFT and GAP, 0 in IDLE.
- data_i is sampled only on the accept edge; later changes have no effect on the word in flight.
- Illegal state encoding: recover to IDLE on the next edge; outputs take their IDLE values.

Decomposition:
- Shared package pattern_pkg:
  - State encodings S_IDLE, S_SHIFT, S_GAP.
  - Symbol constants B=1'b0, C=1'b1.
  - Detector pattern constant PAT_BCCBC=5'b01101.
  - The package is reused by the detector and the bench.
- No sub-module needed. Shift register, bit counter and gap counter are one process each within the module.

Test Plan:
- Reset then single load: rst 2 cycles, then load data_i=8'b0110_1101, MSB_FIRST=1.
  - Required: valid_o high for exactly 8 cycles starting 1 cycle after accept.
  - d_o sequence = 0,1,1,0,1,1,0,1.
  - words_sent_o=1.
  - Fed to the detector, pattern fires twice (overlapping BCCBC).
- Back-to-back, GAP=0: hold load_i=1 with words 8'hA5 then 8'h3C.
  - Required: 16 consecutive valid_o=1 cycles.
  - d_o=1010_0101_0011_1100.
  - ready_o high only in the IDLE cycle and the two last-bit cycles.
  - words_sent_o=2.
- Gap insertion, GAP=3, load_i held high.
  - Required: each 8-bit burst is followed by 3 cycles of valid_o=0, d_o=0, busy_o=1, then 1 IDLE cycle before the next burst.
- LSB-first, MSB_FIRST=0, data_i=8'b0000_0001.
  - Required: d_o = 1,0,0,0,0,0,0,0.
- Mid-word reset: assert rst on the 4th bit.
  - Required: next cycle valid_o=0, d_o=0, words_sent_o=0, ready_o=1.
  - A fresh load then transmits all 8 bits.
- Ignored load and counter wrap:
  - load_i pulsed during SHIFT → no effect on the bit sequence or count.
  - With CNT_W=2, send 5 words → words_sent_o reads 1.
